// File: rtl/fetch_unit.sv
// IF stage of the 16-bit CPU: owns the PC, drives instruction memory and fills the
// IF/ID register, with stall, redirect, halt detection and a saturating fetch counter.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned MEM_BYTES   = 128,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [15:0] RedirectTarget,
    input  logic [15:0] Instruction,
    output logic [15:0] PCAddress,
    output logic [15:0] IFID_Instruction,
    output logic [15:0] IFID_PC,
    output logic [15:0] IFID_PCPlus2,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic        MisalignFlag,
    output logic [15:0] FetchCount
);

    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    logic [15:0] pc_plus2;
    logic [15:0] redirect_pc;
    logic [15:0] instr_next, ifid_pc_next, ifid_pc2_next, count_next;
    logic        valid_next, misalign_next;
    logic        is_halt_word;

    // Sequential fetch and redirect both wrap inside the memory and stay word aligned.
    assign pc_plus2     = (pc + 16'd2) & ADDR_MASK;
    assign redirect_pc  = RedirectTarget & ADDR_MASK & 16'hFFFE;
    assign is_halt_word = (Instruction[15:12] == HALT_OPCODE);

    assign PCAddress = pc;
    assign Halted    = (state == HALT);

    // NOTE: every variable gets a hold/default value before the case, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = IFID_Instruction;
        ifid_pc_next  = IFID_PC;
        ifid_pc2_next = IFID_PCPlus2;
        valid_next    = IFID_Valid;
        count_next    = FetchCount;
        misalign_next = 1'b0;

        case (state)
            BOOT: begin
                state_next = RUN;
            end

            RUN: begin
                if (Redirect) begin
                    pc_next       = redirect_pc;
                    valid_next    = 1'b0;
                    misalign_next = RedirectTarget[0];
                end else if (!Stall) begin
                    instr_next    = Instruction;
                    ifid_pc_next  = pc;
                    ifid_pc2_next = pc_plus2;
                    valid_next    = 1'b1;
                    count_next    = (FetchCount == 16'hFFFF) ? FetchCount : FetchCount + 16'd1;
                    pc_next       = pc_plus2;
                    if (is_halt_word) begin
                        state_next = HALT;
                    end
                end
            end

            HALT: begin
                // The halt may have been fetched down a mispredicted path; a redirect revives it.
                valid_next = 1'b0;
                if (Redirect) begin
                    pc_next       = redirect_pc;
                    misalign_next = RedirectTarget[0];
                    state_next    = RUN;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= BOOT;
            pc               <= RESET_PC;
            IFID_Instruction <= 16'h0000;
            IFID_PC          <= 16'h0000;
            IFID_PCPlus2     <= 16'h0000;
            IFID_Valid       <= 1'b0;
            MisalignFlag     <= 1'b0;
            FetchCount       <= 16'h0000;
        end else begin
            state            <= state_next;
            pc               <= pc_next;
            IFID_Instruction <= instr_next;
            IFID_PC          <= ifid_pc_next;
            IFID_PCPlus2     <= ifid_pc2_next;
            IFID_Valid       <= valid_next;
            MisalignFlag     <= misalign_next;
            FetchCount       <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model plus a scoreboard of
// expected IF/ID contents, compared one cycle after each fetch is issued.
module tb_fetch_unit;

    localparam int S_BOOT = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } ifid_t;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [15:0] RedirectTarget;
    logic [15:0] Instruction;
    logic [15:0] PCAddress;
    logic [15:0] IFID_Instruction;
    logic [15:0] IFID_PC;
    logic [15:0] IFID_PCPlus2;
    logic        IFID_Valid;
    logic        Halted;
    logic        MisalignFlag;
    logic [15:0] FetchCount;

    logic [7:0]  mem [0:127];
    logic [6:0]  lo_addr;

    int          n_cmp = 0;
    int          n_err = 0;

    int          m_state;
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_valid;
    logic        m_mis;
    ifid_t       last;
    ifid_t       sb [$];

    fetch_unit dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .Instruction      (Instruction),
        .PCAddress        (PCAddress),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_PCPlus2     (IFID_PCPlus2),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
        .MisalignFlag     (MisalignFlag),
        .FetchCount       (FetchCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Big-endian instruction memory, read combinationally from the PC.
    assign lo_addr     = PCAddress[6:0] + 7'd1;
    assign Instruction = {mem[PCAddress[6:0]], mem[lo_addr]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge with the given inputs; the model predicts, the DUT is checked #1 later.
    task automatic tick(input logic rst, input logic st, input logic rd, input logic [15:0] tgt);
        logic        fetched;
        logic [15:0] word;
        logic [6:0]  a;
        ifid_t       rec;

        Reset          = rst;
        Stall          = st;
        Redirect       = rd;
        RedirectTarget = tgt;
        fetched        = 1'b0;
        a              = m_pc[6:0];
        word           = {mem[a], mem[a + 7'd1]};
        m_mis          = 1'b0;

        if (rst) begin
            m_state = S_BOOT;
            m_pc    = 16'h0000;
            m_valid = 1'b0;
            m_cnt   = 16'h0000;
            last    = '{16'h0000, 16'h0000, 16'h0000};
            sb.delete();
        end else begin
            case (m_state)
                S_BOOT: m_state = S_RUN;
                S_RUN: begin
                    if (rd) begin
                        m_pc    = {9'd0, tgt[6:1], 1'b0};
                        m_valid = 1'b0;
                        m_mis   = tgt[0];
                    end else if (!st) begin
                        rec.instr = word;
                        rec.pc    = m_pc;
                        rec.pc2   = (m_pc + 16'd2) % 16'd128;
                        sb.push_back(rec);
                        fetched   = 1'b1;
                        m_pc      = rec.pc2;
                        m_valid   = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                        if (word[15:12] == 4'hF) m_state = S_HALT;
                    end
                end
                default: begin
                    m_valid = 1'b0;
                    if (rd) begin
                        m_pc    = {9'd0, tgt[6:1], 1'b0};
                        m_mis   = tgt[0];
                        m_state = S_RUN;
                    end
                end
            endcase
        end

        @(posedge Clock);
        #1;

        if (fetched) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else last = sb.pop_front();
        end

        check("pc",        PCAddress,        m_pc);
        check("valid",     IFID_Valid,       m_valid);
        check("halted",    Halted,           (m_state == S_HALT));
        check("misalign",  MisalignFlag,     m_mis);
        check("count",     FetchCount,       m_cnt);
        check("ifid_inst", IFID_Instruction, last.instr);
        check("ifid_pc",   IFID_PC,          last.pc);
        check("ifid_pc2",  IFID_PCPlus2,     last.pc2);
    endtask

    initial begin
        Reset          = 1'b1;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 16'h0000;

        for (int i = 0; i < 128; i++) begin
            mem[i] = (i % 2 == 0) ? 8'(8'h40 + i / 2) : 8'(i);
        end
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'h0E; mem[7] = 8'hF0;
        mem[64] = 8'hF0; mem[65] = 8'h00;

        m_state = S_BOOT;
        m_pc    = 16'h0000;
        m_cnt   = 16'h0000;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        last    = '{16'h0000, 16'h0000, 16'h0000};

        // Reset, BOOT, then three fetches.
        tick(1, 0, 0, 16'h0000);
        check("rst_pc", PCAddress, 16'h0000);
        tick(0, 0, 0, 16'h0000);
        check("boot_pc", PCAddress, 16'h0000);
        check("boot_valid", IFID_Valid, 1'b0);
        repeat (3) tick(0, 0, 0, 16'h0000);
        check("tp1_cnt", FetchCount, 16'd3);
        check("tp1_inst", IFID_Instruction, 16'h9ABC);
        check("tp1_ifpc", IFID_PC, 16'h0004);

        // Fetch the word at 6 then stall three cycles at PC 8.
        tick(0, 0, 0, 16'h0000);
        repeat (3) tick(0, 1, 0, 16'h0000);
        check("stall_pc", PCAddress, 16'h0008);
        check("stall_inst", IFID_Instruction, 16'h0EF0);
        tick(0, 0, 0, 16'h0000);
        check("resume_inst", IFID_Instruction, 16'h4409);

        // Redirect beats stall; odd target is masked and aligned.
        tick(0, 1, 1, 16'h0133);
        check("mis_pc", PCAddress, 16'h0032);
        check("mis_flag", MisalignFlag, 1'b1);
        tick(0, 0, 0, 16'h0000);
        check("mis_clear", MisalignFlag, 1'b0);

        // Wrap from 126 to 0.
        tick(0, 0, 1, 16'h007C);
        repeat (2) tick(0, 0, 0, 16'h0000);
        check("wrap_pc", PCAddress, 16'h0000);
        check("wrap_ifpc", IFID_PC, 16'h007E);
        check("wrap_pc2", IFID_PCPlus2, 16'h0000);

        // HALT, frozen PC with stall ignored, then revive by redirect.
        tick(0, 0, 1, 16'h0040);
        tick(0, 0, 0, 16'h0000);
        check("halt_inst", IFID_Instruction, 16'hF000);
        check("halt_valid", IFID_Valid, 1'b1);
        tick(0, 1, 0, 16'h0000);
        tick(0, 0, 0, 16'h0000);
        check("halted", Halted, 1'b1);
        check("halt_pc", PCAddress, 16'h0042);
        tick(0, 0, 1, 16'h0010);
        check("unhalt", Halted, 1'b0);
        tick(0, 0, 0, 16'h0000);
        check("unhalt_pc", IFID_PC, 16'h0010);

        // Redirect ignored in BOOT; build FetchCount=5 and halt, then reset mid-stream.
        tick(1, 0, 0, 16'h0000);
        tick(0, 0, 1, 16'h0055);
        check("boot_redir", PCAddress, 16'h0000);
        repeat (4) tick(0, 0, 0, 16'h0000);
        tick(0, 0, 1, 16'h0040);
        tick(0, 0, 0, 16'h0000);
        check("pre_rst_cnt", FetchCount, 16'd5);
        check("pre_rst_halt", Halted, 1'b1);
        tick(1, 0, 0, 16'h0000);
        check("mid_rst_pc", PCAddress, 16'h0000);
        check("mid_rst_cnt", FetchCount, 16'd0);
        check("mid_rst_halt", Halted, 1'b0);
        check("mid_rst_inst", IFID_Instruction, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
